// File: rtl/hd_sched_pkg.sv
// Shared types and constants for the hd-series evaluator scheduler.
// Included by the arbiter and the scheduler top.
package hd_sched_pkg;

  localparam int DW_DEF = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/hd_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after
// ptr wins, scanning upward modulo NREQ.
module hd_rr_arbiter import hd_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_gnt
);

  // Scan from the far end so the nearest requester overwrites last.
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        any_gnt = 1'b1;
        gnt_idx = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign gnt = any_gnt ? (NREQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/hd_eval_sched.sv
// Round-robin scheduler sharing one combinational hd-series evaluator
// among NREQ requesters, with a programmable settle latency.
module hd_eval_sched import hd_sched_pkg::*; #(
  parameter int NREQ     = 4,
  parameter int DW       = DW_DEF,
  parameter int EVAL_LAT = 2,
  parameter int IDW      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [DW-1:0]     eval_x,
  input  logic [DW-1:0]     eval_y,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DW-1:0]     resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy,
  output logic [15:0]       op_count
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_reg;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             any_gnt;
  logic [IDW-1:0]   ptr_nxt;

  hd_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign req_ready = (state == S_IDLE) ? gnt : '0;
  assign busy      = (state != S_IDLE);
  assign ptr_nxt   = (int'(gnt_idx) == NREQ - 1) ?
                     '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      id_reg     <= '0;
      eval_x     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      op_count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_gnt) begin
            eval_x <= req_data[int'(gnt_idx)*DW +: DW];
            id_reg <= gnt_idx;
            cnt    <= CNT_W'(EVAL_LAT);
            rr_ptr <= ptr_nxt;
            state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          // eval_x is held; capture once the netlist has settled.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_data  <= eval_y;
            resp_id    <= id_reg;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            op_count   <= op_count + 16'd1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_eval_sched.sv
// Randomized self-checking bench for hd_eval_sched against a
// transaction-level round-robin model.
module tb_hd_eval_sched;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam logic [31:0] XM = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   eval_x, eval_y, resp_data;
  logic            resp_valid, resp_ready, busy;
  logic [1:0]      resp_id;
  logic [15:0]     op_count;

  logic [N-1:0]    req_valid_b, req_ready_b;
  logic [N*DW-1:0] req_data_b;
  logic [DW-1:0]   eval_x_b, eval_y_b, resp_data_b;
  logic            resp_valid_b, resp_ready_b, busy_b;
  logic [1:0]      resp_id_b;
  logic [15:0]     op_count_b;

  assign eval_y   = eval_x ^ XM;
  assign eval_y_b = eval_x_b ^ XM;

  hd_eval_sched #(.NREQ(N), .DW(DW), .EVAL_LAT(LAT), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eval_x(eval_x), .eval_y(eval_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id),
    .busy(busy), .op_count(op_count)
  );

  hd_eval_sched #(.NREQ(N), .DW(DW), .EVAL_LAT(0), .IDW(2)) dutb (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_data(req_data_b), .req_ready(req_ready_b),
    .eval_x(eval_x_b), .eval_y(eval_y_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_data(resp_data_b), .resp_id(resp_id_b),
    .busy(busy_b), .op_count(op_count_b)
  );

  int n_chk = 0;
  int n_err = 0;
  int ptr   = 0;
  int cnt_m = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic rand_data;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  task automatic run_op(input logic [N-1:0] m, input logic [31:0] d,
                        input int bp);
    int g, lat;
    logic [N-1:0] oh;
    logic [31:0] exp_d;
    g = pick(m);
    rand_data();
    req_data[g*DW +: DW] = d;
    req_valid = m;
    #1;
    oh = '0;
    oh[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(oh));
    exp_d = d ^ XM;
    tick();
    req_valid = N'($urandom);
    rand_data();
    ptr = (g + 1) % N;
    lat = 1;
    #1;
    while (!resp_valid && lat < 40) begin
      check("ready_eval", 32'(req_ready), 32'd0);
      check("eval_x_hold", eval_x, d);
      tick();
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT + 2));
    check("resp_data", resp_data, exp_d);
    check("resp_id", 32'(resp_id), 32'(g));
    check("busy_resp", 32'(busy), 32'd1);
    resp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      req_valid = N'($urandom);
      tick();
      #1;
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_data", resp_data, exp_d);
      check("bp_id", 32'(resp_id), 32'(g));
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    req_valid = '0;
    resp_ready = 1'b1;
    tick();
    #1;
    resp_ready = 1'b0;
    cnt_m++;
    check("valid_drop", 32'(resp_valid), 32'd0);
    check("op_count", 32'(op_count), 32'(cnt_m[15:0]));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, cyc, last, lat, rv;
    logic [31:0] d;
    rst_n = 1'b1;
    req_valid = '0; req_data = '0; resp_ready = 1'b0;
    req_valid_b = '0; req_data_b = '0; resp_ready_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_eval_x", eval_x, 32'd0);
    check("rst_data", resp_data, 32'd0);
    check("rst_id", 32'(resp_id), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    check("rst_valid_b", 32'(resp_valid_b), 32'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();

    // round robin with every requester asking
    rand_data();
    req_valid = '1;
    resp_ready = 1'b1;
    n = 0; cyc = 0; last = 0;
    while (n < 5 && cyc < 60) begin
      #1;
      if (resp_valid) begin
        check("rr_id", 32'(resp_id), 32'((ptr + n) % N));
        if (n > 0) check("rr_period", 32'(cyc - last), 32'd5);
        last = cyc;
        n++;
        if (n == 5) req_valid = '0;
      end
      tick();
      cyc++;
    end
    check("rr_count", 32'(n), 32'd5);
    resp_ready = 1'b0;
    cnt_m += 5;
    ptr = 1;
    check("rr_opcount", 32'(op_count), 32'(cnt_m));

    // single request, then fairness around the wrap
    run_op(4'b0010, 32'h0000_00F0, 0);
    run_op(4'b0011, $urandom, 0);
    run_op(4'b0011, $urandom, 0);
    run_op(4'b1111, $urandom, 10);

    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        tick();
        #1;
        check("idle_stay", 32'(busy), 32'd0);
      end
      run_op(N'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3));
    end

    // reset while the settle counter is at 1
    rand_data();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_valid", 32'(resp_valid), 32'd0);
    check("mr_eval_x", eval_x, 32'd0);
    check("mr_data", resp_data, 32'd0);
    check("mr_id", 32'(resp_id), 32'd0);
    check("mr_count", 32'(op_count), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    ptr = 0;
    cnt_m = 0;
    rv = 0;
    repeat (8) begin
      tick();
      #1;
      if (resp_valid) rv++;
    end
    check("mr_no_resp", 32'(rv), 32'd0);
    run_op(4'b1000, $urandom, 1);

    // zero-latency instance and counter wrap
    force dutb.op_count = 16'hFFFF;
    #1;
    release dutb.op_count;
    #1;
    check("b_forced", 32'(op_count_b), 32'h0000_FFFF);
    d = $urandom;
    req_data_b = '0;
    req_data_b[DW-1:0] = d;
    req_valid_b = 4'b0001;
    #1;
    check("b_ready", 32'(req_ready_b), 32'd1);
    tick();
    req_valid_b = '0;
    lat = 1;
    #1;
    while (!resp_valid_b && lat < 20) begin
      tick();
      #1;
      lat++;
    end
    check("b_latency", 32'(lat), 32'd2);
    check("b_data", resp_data_b, d ^ XM);
    check("b_id", 32'(resp_id_b), 32'd0);
    resp_ready_b = 1'b1;
    tick();
    #1;
    resp_ready_b = 1'b0;
    check("b_wrap", 32'(op_count_b), 32'd0);
    check("b_valid_drop", 32'(resp_valid_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
